// File: rtl/uart_err_monitor.sv
// ---------------------------------------------------------------------------
// uart_err_monitor
//   Watches the UART RX error levels and the frame-valid strobe. Converts the
//   error levels into single-cycle events, keeps saturating lifetime counters,
//   a sticky error flag, and a per-window error-rate alarm that stays raised
//   until acknowledged.
//
// Ports
//   CLK          system clock (REF_CLK domain)
//   RST          asynchronous active-high reset
//   PAR_Err      parity error level (already synchronised)
//   Frame_Err    framing error level (already synchronised)
//   RX_DATA_VLD  one-cycle pulse per received frame
//   CLR          one-cycle synchronous clear of counters, flag, window, alarm
//   ALARM_ACK    acknowledge pulse for ALARM
//   PAR_CNT      saturating parity-event count
//   FRM_CNT      saturating framing-event count
//   ERR_FLAG     sticky "an error event has been seen"
//   ALARM        window error count reached ERR_THRESH
//   WIN_ERR      error events in the current window (saturates at WIN_SIZE)
// ---------------------------------------------------------------------------
module uart_err_monitor #(
  parameter int CNT_WD     = 8,
  parameter int WIN_SIZE   = 16,
  parameter int ERR_THRESH = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      PAR_Err,
  input  logic                      Frame_Err,
  input  logic                      RX_DATA_VLD,
  input  logic                      CLR,
  input  logic                      ALARM_ACK,
  output logic [CNT_WD-1:0]         PAR_CNT,
  output logic [CNT_WD-1:0]         FRM_CNT,
  output logic                      ERR_FLAG,
  output logic                      ALARM,
  output logic [$clog2(WIN_SIZE):0] WIN_ERR
);

  localparam int FW = $clog2(WIN_SIZE);
  localparam int WW = FW + 1;

  typedef enum logic {S_MONITOR = 1'b0, S_ALARM = 1'b1} state_t;

  logic              r_par_q, r_frm_q;
  logic [CNT_WD-1:0] r_par_cnt, r_frm_cnt_life;
  logic              r_err_flag;
  logic [FW-1:0]     r_frame_cnt;
  logic [WW-1:0]     r_win_err;
  state_t            r_state, w_next_state;

  logic              w_par_ev, w_frm_ev, w_ev, w_close, w_hit;
  logic [WW:0]       w_win_total;

  // Saturating increment helpers: counters stick at their ceiling.
  function automatic logic [CNT_WD-1:0] sat_inc_cnt(input logic [CNT_WD-1:0] v,
                                                    input logic en);
    return (en && (v != {CNT_WD{1'b1}})) ? v + 1'b1 : v;
  endfunction

  function automatic logic [WW-1:0] sat_inc_win(input logic [WW-1:0] v,
                                                input logic en);
    return (en && (v != WW'(WIN_SIZE))) ? v + 1'b1 : v;
  endfunction

  // Rising-edge detection; a level held for many cycles is one event.
  assign w_par_ev = PAR_Err & ~r_par_q;
  assign w_frm_ev = Frame_Err & ~r_frm_q;
  assign w_ev     = w_par_ev | w_frm_ev;

  // The valid that brings the frame count to WIN_SIZE closes the window; an
  // event arriving in that same cycle is credited to the closing window.
  assign w_close     = RX_DATA_VLD && (r_frame_cnt == FW'(WIN_SIZE - 1));
  assign w_win_total = {1'b0, r_win_err} + (WW + 1)'(w_ev);
  assign w_hit       = w_close && (w_win_total >= (WW + 1)'(ERR_THRESH));

  // Edge registers keep tracking through CLR so a held level is not recounted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_par_q <= 1'b0;
      r_frm_q <= 1'b0;
    end else begin
      r_par_q <= PAR_Err;
      r_frm_q <= Frame_Err;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_par_cnt      <= '0;
      r_frm_cnt_life <= '0;
      r_err_flag     <= 1'b0;
    end else if (CLR) begin
      r_par_cnt      <= '0;
      r_frm_cnt_life <= '0;
      r_err_flag     <= 1'b0;
    end else begin
      r_par_cnt      <= sat_inc_cnt(r_par_cnt, w_par_ev);
      r_frm_cnt_life <= sat_inc_cnt(r_frm_cnt_life, w_frm_ev);
      if (w_ev) r_err_flag <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_frame_cnt <= '0;
      r_win_err   <= '0;
    end else if (CLR || w_close) begin
      r_frame_cnt <= '0;
      r_win_err   <= '0;
    end else begin
      if (RX_DATA_VLD) r_frame_cnt <= r_frame_cnt + 1'b1;
      r_win_err <= sat_inc_win(r_win_err, w_ev);
    end
  end

  // FSM: state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_MONITOR;
    else     r_state <= w_next_state;
  end

  // FSM: next state. A hit in the same cycle as an ack keeps the alarm up.
  always_comb begin
    w_next_state = r_state;
    if (CLR) begin
      w_next_state = S_MONITOR;
    end else begin
      case (r_state)
        S_MONITOR: if (w_hit) w_next_state = S_ALARM;
        S_ALARM:   if (ALARM_ACK && !w_hit) w_next_state = S_MONITOR;
        default:   w_next_state = S_MONITOR;
      endcase
    end
  end

  // FSM: outputs (decoded from the state register only)
  always_comb begin
    ALARM = (r_state == S_ALARM);
  end

  assign PAR_CNT  = r_par_cnt;
  assign FRM_CNT  = r_frm_cnt_life;
  assign ERR_FLAG = r_err_flag;
  assign WIN_ERR  = r_win_err;

endmodule

// File: tb/tb_uart_err_monitor.sv
// ---------------------------------------------------------------------------
// tb_uart_err_monitor
//   Self-checking bench for uart_err_monitor (default parameters). Applies a
//   table of hand-computed vectors, directed window/alarm/saturation/clear
//   sequences, and random traffic, comparing every cycle against a
//   behavioural model of the monitor's rules.
// ---------------------------------------------------------------------------
module tb_uart_err_monitor;

  localparam int CNT_WD   = 8;
  localparam int WIN_SIZE = 16;
  localparam int THRESH   = 4;
  localparam int CNT_MAX  = (1 << CNT_WD) - 1;

  logic              CLK = 1'b0;
  logic              RST;
  logic              PAR_Err, Frame_Err, RX_DATA_VLD, CLR, ALARM_ACK;
  logic [CNT_WD-1:0] PAR_CNT, FRM_CNT;
  logic              ERR_FLAG, ALARM;
  logic [4:0]        WIN_ERR;

  uart_err_monitor #(.CNT_WD(CNT_WD), .WIN_SIZE(WIN_SIZE), .ERR_THRESH(THRESH)) dut (
    .CLK(CLK), .RST(RST), .PAR_Err(PAR_Err), .Frame_Err(Frame_Err),
    .RX_DATA_VLD(RX_DATA_VLD), .CLR(CLR), .ALARM_ACK(ALARM_ACK),
    .PAR_CNT(PAR_CNT), .FRM_CNT(FRM_CNT), .ERR_FLAG(ERR_FLAG),
    .ALARM(ALARM), .WIN_ERR(WIN_ERR)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Behavioural model state
  int m_pc, m_fc, m_flag, m_alarm, m_win, m_frames;
  bit m_pp, m_fp;

  typedef struct {
    bit p, f, v, c, a;
    int pc, fc, flag, alarm, win;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_fc = 0; m_flag = 0; m_alarm = 0; m_win = 0; m_frames = 0;
    m_pp = 0; m_fp = 0;
  endtask

  task automatic model_update(input bit p, input bit f, input bit v,
                              input bit c, input bit a);
    bit pe, fe, ev, hit;
    pe = p && !m_pp;
    fe = f && !m_fp;
    ev = pe || fe;
    m_pp = p;
    m_fp = f;
    if (c) begin
      m_pc = 0; m_fc = 0; m_flag = 0; m_alarm = 0; m_win = 0; m_frames = 0;
    end else begin
      if (pe && m_pc < CNT_MAX) m_pc++;
      if (fe && m_fc < CNT_MAX) m_fc++;
      if (ev) m_flag = 1;
      hit = 0;
      if (v && m_frames == WIN_SIZE - 1) begin
        hit = (m_win + int'(ev)) >= THRESH;
        m_frames = 0;
        m_win = 0;
      end else begin
        if (v) m_frames++;
        if (ev && m_win < WIN_SIZE) m_win++;
      end
      if (m_alarm == 1 && a) m_alarm = 0;
      if (hit) m_alarm = 1;
    end
  endtask

  task automatic chk_model();
    chk("mdl_par_cnt", int'(PAR_CNT), m_pc);
    chk("mdl_frm_cnt", int'(FRM_CNT), m_fc);
    chk("mdl_err_flag", int'(ERR_FLAG), m_flag);
    chk("mdl_alarm", int'(ALARM), m_alarm);
    chk("mdl_win_err", int'(WIN_ERR), m_win);
  endtask

  // Apply inputs at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input bit p, input bit f, input bit v, input bit c, input bit a);
    PAR_Err = p; Frame_Err = f; RX_DATA_VLD = v; CLR = c; ALARM_ACK = a;
    @(posedge CLK);
    #1;
    cyc++;
    model_update(p, f, v, c, a);
    chk_model();
    @(negedge CLK);
  endtask

  // One full window: 16 valids, the last n_err of them carry a fresh Frame_Err
  // rise, so the final error coincides with the closing valid.
  task automatic run_window(input int n_err, input bit ack_close, input int exp_alarm);
    for (int fr = 0; fr < WIN_SIZE; fr++) begin
      step(1'b0, fr >= WIN_SIZE - n_err, 1'b1, 1'b0, (fr == WIN_SIZE - 1) && ack_close);
      if (fr == WIN_SIZE - 1) begin
        chk("win_close_alarm", int'(ALARM), exp_alarm);
        chk("win_close_win_err", int'(WIN_ERR), 0);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    RST = 1'b1;
    PAR_Err = 0; Frame_Err = 0; RX_DATA_VLD = 0; CLR = 0; ALARM_ACK = 0;
    model_reset();

    //           p f v c a   pc fc fl al win
    tbl[0]  = '{1,0,0,0,0,   1, 0, 1, 0, 1};
    tbl[1]  = '{1,0,0,0,0,   1, 0, 1, 0, 1};
    tbl[2]  = '{1,0,0,0,0,   1, 0, 1, 0, 1};
    tbl[3]  = '{1,0,0,0,0,   1, 0, 1, 0, 1};
    tbl[4]  = '{1,0,0,0,0,   1, 0, 1, 0, 1};
    tbl[5]  = '{0,0,0,0,0,   1, 0, 1, 0, 1};
    tbl[6]  = '{1,1,0,0,0,   2, 1, 1, 0, 2};
    tbl[7]  = '{0,0,0,0,0,   2, 1, 1, 0, 2};
    tbl[8]  = '{0,0,0,1,0,   0, 0, 0, 0, 0};
    tbl[9]  = '{1,1,0,0,0,   1, 1, 1, 0, 1};
    tbl[10] = '{1,1,0,1,0,   0, 0, 0, 0, 0};
    tbl[11] = '{1,1,0,0,0,   0, 0, 0, 0, 0};
    tbl[12] = '{0,0,0,0,0,   0, 0, 0, 0, 0};
    tbl[13] = '{1,0,0,0,0,   1, 0, 1, 0, 1};
    tbl[14] = '{0,0,0,0,0,   1, 0, 1, 0, 1};

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_par_cnt", int'(PAR_CNT), 0);
    chk("rst_frm_cnt", int'(FRM_CNT), 0);
    chk("rst_err_flag", int'(ERR_FLAG), 0);
    chk("rst_alarm", int'(ALARM), 0);
    chk("rst_win_err", int'(WIN_ERR), 0);
    RST = 1'b0;

    // Table-driven vectors: edge detection, coincident events, CLR with held level
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].p, tbl[i].f, tbl[i].v, tbl[i].c, tbl[i].a);
      chk("tbl_par_cnt", int'(PAR_CNT), tbl[i].pc);
      chk("tbl_frm_cnt", int'(FRM_CNT), tbl[i].fc);
      chk("tbl_err_flag", int'(ERR_FLAG), tbl[i].flag);
      chk("tbl_alarm", int'(ALARM), tbl[i].alarm);
      chk("tbl_win_err", int'(WIN_ERR), tbl[i].win);
    end

    // Window / alarm sequences
    step(0, 0, 0, 1, 0);
    run_window(4, 1'b0, 1);
    step(0, 0, 0, 0, 1);
    chk("ack_clears_alarm", int'(ALARM), 0);
    run_window(3, 1'b0, 0);
    run_window(5, 1'b0, 1);
    run_window(4, 1'b1, 1);
    chk("ack_with_hit_keeps", int'(ALARM), 1);
    step(0, 0, 0, 0, 1);
    chk("ack_after_hit_ack", int'(ALARM), 0);
    step(0, 0, 0, 0, 1);
    chk("ack_in_monitor", int'(ALARM), 0);

    // Counter saturation
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < 300; k++) begin
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
    end
    chk("sat_par_cnt", int'(PAR_CNT), CNT_MAX);
    chk("sat_frm_cnt", int'(FRM_CNT), 0);
    chk("sat_win_err", int'(WIN_ERR), WIN_SIZE);

    // CLR while PAR_Err held high and ALARM set
    step(0, 0, 0, 1, 0);
    run_window(4, 1'b0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("clr_par_cnt", int'(PAR_CNT), 0);
    chk("clr_err_flag", int'(ERR_FLAG), 0);
    chk("clr_alarm", int'(ALARM), 0);
    chk("clr_win_err", int'(WIN_ERR), 0);
    step(1, 0, 0, 0, 0);
    chk("clr_held_no_event", int'(PAR_CNT), 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("clr_rise_again", int'(PAR_CNT), 1);

    // Asynchronous reset mid-window
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    Frame_Err = 0; PAR_Err = 0; RX_DATA_VLD = 0;
    RST = 1'b1;
    #1;
    chk("arst_par_cnt", int'(PAR_CNT), 0);
    chk("arst_frm_cnt", int'(FRM_CNT), 0);
    chk("arst_err_flag", int'(ERR_FLAG), 0);
    chk("arst_win_err", int'(WIN_ERR), 0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
           $urandom_range(0, 9) < 4, $urandom_range(0, 99) == 0,
           $urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
